// File: rtl/nibble_serial_logic_unit.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_logic_unit
// Description : Slices WIDTH-bit operands into SLICE-bit pieces, runs them one
//               per cycle (LSB first) through a shared bitwise datapath and
//               reassembles the result behind valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_logic_unit #(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int c_nslice = WIDTH / SLICE;
    localparam int c_cw     = (c_nslice > 1) ? $clog2(c_nslice) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(c_nslice - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_cw-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [1:0]        r_op;
    logic [WIDTH-1:0]  r_result;
    logic              r_zero;
    logic              r_out_valid;
    logic [WIDTH-1:0]  w_result_next;

    function automatic logic [SLICE-1:0] slice_op(
        input logic [SLICE-1:0] x,
        input logic [SLICE-1:0] y,
        input logic [1:0]       o
    );
        case (o)
            2'b00:   slice_op = x & y;
            2'b01:   slice_op = x | y;
            2'b10:   slice_op = x ^ y;
            default: slice_op = ~(x | y);
        endcase
    endfunction

    // Only the slice addressed by the counter changes; unwritten slices stay 0.
    always_comb begin
        w_result_next = r_result;
        for (int k = 0; k < c_nslice; k++) begin
            if (r_cnt == c_cw'(k)) begin
                w_result_next[k*SLICE +: SLICE] =
                    slice_op(r_a[k*SLICE +: SLICE], r_b[k*SLICE +: SLICE], r_op);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_op     <= op;
                        r_cnt    <= '0;
                        r_result <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_result <= w_result_next;
                    if (r_cnt == c_last) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_zero      <= (w_result_next == '0);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_logic_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_logic_unit
// Description : Scoreboard bench for nibble_serial_logic_unit: directed cases
//               plus randomized bundles against a whole-word bitwise model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_logic_unit;

    localparam int WIDTH  = 8;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [1:0]       op = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] result;
    logic             zero;

    nibble_serial_logic_unit #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             zf;
        int               acc_cycle;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycle    = 0;
    bit   rand_ready = 1'b0;

    always @(posedge clk) cycle++;

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic [1:0] o);
        case (o)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: pops one expectation per presented result, then checks hold stability.
    logic             prev_v = 1'b0;
    logic [WIDTH-1:0] held_res;
    logic             held_zero;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    check("spurious_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", 64'(result), 64'(e.res));
                    check("zero", 64'(zero), 64'(e.zf));
                    check("latency", 64'(cycle - e.acc_cycle), 64'(NSLICE));
                end
                held_res  = result;
                held_zero = zero;
            end else if (out_valid && prev_v) begin
                check("hold_result", 64'(result), 64'(held_res));
                check("hold_zero", 64'(zero), 64'(held_zero));
            end
            prev_v = out_valid;
        end
    end

    always @(negedge clk) if (rand_ready) out_ready = 1'($urandom_range(0, 1));

    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic [1:0] top);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        a = ta; b = tb; op = top; in_valid = 1'b1;
        e.res = model(ta, tb, top);
        e.zf  = (e.res == '0);
        e.acc_cycle = cycle + 1;
        sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        // 1: reset then idle
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_zero", 64'(zero), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // 2: OR with in_ready low for exactly three cycles
        out_ready = 1'b1;
        send(8'hA5, 8'h5A, 2'b01);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("busy_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // 3: all ops on fixed operands
        for (int o = 0; o < 4; o++) send(8'hC3, 8'h0F, 2'(o));
        drain();

        // 4: zero flag, backpressure, ignored in_valid during stall
        out_ready = 1'b0;
        send(8'h3C, 8'h3C, 2'b10);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            a = 8'($urandom); b = 8'($urandom); op = 2'($urandom); in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_out_valid", 64'(out_valid), 64'd0);
        check("release_in_ready", 64'(in_ready), 64'd1);
        send(8'h81, 8'h18, 2'b01);

        // 5: operand change after capture
        send(8'hF0, 8'h0F, 2'b00);
        a = 8'hFF; b = 8'hFF; op = 2'b01;
        drain();

        // 6: reset between the two slice cycles
        send(8'hFF, 8'h00, 2'b01);
        @(posedge clk);
        #1;
        check("partial_result", 64'(result), 64'h0F);
        check("partial_out_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_zero", 64'(zero), 64'd0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        send(8'h12, 8'h34, 2'b01);
        drain();

        // Randomized bundles with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) send(8'($urandom), 8'($urandom), 2'($urandom));
        @(negedge clk);
        rand_ready = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
